core_busif: RTL and testbench

CORE_BUSIF -- requirements
Module: core_busif

---
 rtl/core_busif_pkg.sv | 12 +
 rtl/core_busif.sv | 136 +++++++++++++
 tb/tb_core_busif.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_busif_pkg.sv
// Shared definitions for the core bus interface: FSM encoding and default timeout.
package core_busif_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StData  = 2'd2
  } busif_state_e;

  localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/core_busif.sv
// Core-to-memory bus interface: arbitrates instruction fetch and load/store onto one
// request/ready bus, with data priority, wait counting and a sticky timeout flag.
module core_busif
  import core_busif_pkg::*;
#(
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_in,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_out,
  input  logic [3:0]  data_w,
  input  logic        data_access,
  output logic [31:0] data_in,
  output logic        stall,
  output logic        mwait,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_we,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        bus_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  busif_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic          bus_err_q, bus_err_d;
  logic [29:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   din_q, din_d;

  logic        in_idle, in_fetch, in_data;
  logic        waiting, timeout, complete;
  logic        pend_set, data_done;
  logic [31:0] rdata;

  // Byte offsets never reach the bus; addresses are always word-aligned.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[1:0], data_addr[1:0]};

  always_comb begin
    in_idle   = (state_q == StIdle);
    in_fetch  = (state_q == StFetch);
    in_data   = (state_q == StData);
    waiting   = ~in_idle & ~mem_ready;
    timeout   = waiting & (cnt_q == CntW'(TIMEOUT - 1));
    complete  = ~in_idle & (mem_ready | timeout);
    rdata     = mem_ready ? mem_rdata : 32'h0;
    // The IDLE cycle takes no requests so mwait stays low there.
    pend_set  = data_access & ~pend_q & ~in_idle;
    data_done = in_data & complete;
  end

  always_comb begin
    pend_d    = data_done ? 1'b0 : (pend_q | pend_set);
    addr_d    = pend_set ? data_addr[31:2] : addr_q;
    wdata_d   = pend_set ? data_out : wdata_q;
    be_d      = pend_set ? data_w : be_q;
    inst_d    = (in_fetch & complete) ? rdata : inst_q;
    din_d     = data_done ? rdata : din_q;
    bus_err_d = bus_err_q | timeout;
    if (complete) begin
      cnt_d = '0;
    end else if (waiting) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:         state_d = StFetch;
      StFetch, StData: begin
        if (complete) begin
          state_d = pend_d ? StData : StFetch;
        end
      end
      default:        state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      bus_err_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      inst_q    <= '0;
      din_q     <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      bus_err_q <= bus_err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      inst_q    <= inst_d;
      din_q     <= din_d;
    end
  end

  always_comb begin
    mem_req   = ~in_idle;
    mem_addr  = in_data ? {addr_q, 2'b00} : {inst_addr[31:2], 2'b00};
    mem_wdata = wdata_q;
    mem_be    = in_data ? be_q : 4'b0000;
    mem_we    = in_data & (|be_q);
    inst_in   = inst_d;
    data_in   = din_d;
    stall     = in_idle | (waiting & ~timeout) | (pend_q & ~data_done);
    mwait     = pend_set | (pend_q & ~data_done);
    bus_err   = bus_err_q;
  end

endmodule

// File: tb/tb_core_busif.sv
// Directed scenarios plus a randomized run checked against a transaction-level model.
module tb_core_busif;

  localparam int unsigned TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] inst_addr, inst_in, data_addr, data_out, data_in;
  logic [3:0]  data_w, mem_be;
  logic        data_access, stall, mwait, mem_we, mem_req, mem_ready, bus_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  core_busif #(.TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset),
    .inst_addr(inst_addr), .inst_in(inst_in),
    .data_addr(data_addr), .data_out(data_out), .data_w(data_w),
    .data_access(data_access), .data_in(data_in),
    .stall(stall), .mwait(mwait),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_we(mem_we),
    .mem_req(mem_req), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .bus_err(bus_err)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_addr = '0; data_addr = '0; data_out = '0; data_w = '0;
    data_access = 1'b0; mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    data_access = 1'b1;
    sample();
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", mem_req); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %b want 1", stall); end
    n_checks++; if (mwait !== 1'b0) begin n_fail++; $display("FAIL reset_mwait got %b want 0", mwait); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", bus_err); end
    n_checks++; if (inst_in !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst_in); end
    n_checks++; if (data_in !== 32'h0) begin n_fail++; $display("FAIL reset_din got %h want 0", data_in); end
    n_checks++; if ({mem_be, mem_we} !== 5'b0) begin n_fail++; $display("FAIL reset_be_we got %b want 0", {mem_be, mem_we}); end
    data_access = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] w;
    mem_ready = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    sample();
    n_checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL idle_cycle got req=%b stall=%b want req=0 stall=1", mem_req, stall);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      inst_addr = 32'(i * 4);
      w = $urandom;
      mem_rdata = w;
      sample();
      n_checks++; if (mem_addr !== 32'(i * 4)) begin n_fail++; $display("FAIL zw_addr%0d got %h want %h", i, mem_addr, i * 4); end
      n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zw_stall%0d got %b want 0", i, stall); end
      n_checks++; if (inst_in !== w) begin n_fail++; $display("FAIL zw_inst%0d got %h want %h", i, inst_in, w); end
    end
  endtask

  task automatic test_wait_fetch();
    logic [31:0] prev, w;
    prev = inst_in;
    for (int i = 0; i < 2; i++) begin
      tick();
      inst_addr = 32'h100; mem_ready = 1'b0; mem_rdata = $urandom;
      sample();
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wf_stall%0d got %b want 1", i, stall); end
      n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL wf_addr%0d got %h want 100", i, mem_addr); end
      n_checks++; if (inst_in !== prev) begin n_fail++; $display("FAIL wf_hold%0d got %h want %h", i, inst_in, prev); end
    end
    tick();
    w = $urandom; mem_ready = 1'b1; mem_rdata = w;
    sample();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL wf_ready_stall got %b want 0", stall); end
    n_checks++; if (inst_in !== w) begin n_fail++; $display("FAIL wf_ready_inst got %h want %h", inst_in, w); end
  endtask

  task automatic test_store_during_fetch();
    logic [31:0] sd, w;
    sd = $urandom;
    tick();
    inst_addr = 32'h200; mem_ready = 1'b0;
    data_access = 1'b1; data_addr = 32'h2003; data_w = 4'b0001; data_out = sd;
    for (int i = 0; i < 3; i++) begin
      sample();
      n_checks++; if (mwait !== 1'b1 || stall !== 1'b1) begin
        n_fail++; $display("FAIL st_wait%0d got mwait=%b stall=%b want 1 1", i, mwait, stall);
      end
      n_checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h200) begin
        n_fail++; $display("FAIL st_fetch%0d got we=%b addr=%h want 0 200", i, mem_we, mem_addr);
      end
      tick();
      data_access = 1'b0; data_addr = $urandom; data_w = 4'hF; data_out = $urandom;
    end
    w = $urandom; mem_ready = 1'b1; mem_rdata = w;
    sample();
    n_checks++; if (inst_in !== w) begin n_fail++; $display("FAIL st_fetch_done got %h want %h", inst_in, w); end
    n_checks++; if (stall !== 1'b1 || mwait !== 1'b1) begin
      n_fail++; $display("FAIL st_fetch_done_flags got stall=%b mwait=%b want 1 1", stall, mwait);
    end
    tick();
    mem_ready = 1'b0;
    sample();
    n_checks++; if (mem_addr !== 32'h2000) begin n_fail++; $display("FAIL st_addr got %h want 2000", mem_addr); end
    n_checks++; if (mem_be !== 4'b0001 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL st_be_we got be=%b we=%b want 0001 1", mem_be, mem_we);
    end
    n_checks++; if (mem_wdata !== sd) begin n_fail++; $display("FAIL st_wdata got %h want %h", mem_wdata, sd); end
    n_checks++; if (stall !== 1'b1 || mwait !== 1'b1) begin
      n_fail++; $display("FAIL st_data_wait got stall=%b mwait=%b want 1 1", stall, mwait);
    end
    tick();
    mem_ready = 1'b1;
    sample();
    n_checks++; if (stall !== 1'b0 || mwait !== 1'b0) begin
      n_fail++; $display("FAIL st_done got stall=%b mwait=%b want 0 0", stall, mwait);
    end
    tick();
    sample();
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 32'h200 || mwait !== 1'b0) begin
      n_fail++; $display("FAIL st_back got we=%b addr=%h mwait=%b want 0 200 0", mem_we, mem_addr, mwait);
    end
  endtask

  task automatic test_load();
    tick();
    mem_ready = 1'b1; mem_rdata = $urandom;
    data_access = 1'b1; data_addr = 32'h3008; data_w = 4'b0000; data_out = $urandom;
    sample();
    n_checks++; if (stall !== 1'b0 || mwait !== 1'b1) begin
      n_fail++; $display("FAIL ld_issue got stall=%b mwait=%b want 0 1", stall, mwait);
    end
    tick();
    data_access = 1'b0; mem_ready = 1'b0;
    sample();
    n_checks++; if (mem_we !== 1'b0 || mem_be !== 4'b0 || mem_addr !== 32'h3008) begin
      n_fail++; $display("FAIL ld_bus got we=%b be=%b addr=%h want 0 0 3008", mem_we, mem_be, mem_addr);
    end
    n_checks++; if (mwait !== 1'b1) begin n_fail++; $display("FAIL ld_mwait got %b want 1", mwait); end
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hA1B2C3D4;
    sample();
    n_checks++; if (data_in !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL ld_data got %h want a1b2c3d4", data_in); end
    n_checks++; if (mwait !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("FAIL ld_done got mwait=%b stall=%b want 0 0", mwait, stall);
    end
    tick();
    mem_rdata = 32'h0BAD_F00D;
    sample();
    n_checks++; if (data_in !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL ld_hold got %h want a1b2c3d4", data_in); end
  endtask

  task automatic test_timeout();
    for (int i = 1; i <= int'(TO); i++) begin
      tick();
      inst_addr = 32'h400; mem_ready = 1'b0; mem_rdata = $urandom;
      sample();
      if (i < int'(TO)) begin
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL to_wait%0d got %b want 1", i, stall); end
      end else begin
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL to_fire_stall got %b want 0", stall); end
        n_checks++; if (inst_in !== 32'h0) begin n_fail++; $display("FAIL to_inst got %h want 0", inst_in); end
      end
      n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL to_err_early%0d got %b want 0", i, bus_err); end
    end
    tick();
    inst_addr = 32'h404;
    sample();
    n_checks++; if (bus_err !== 1'b1) begin n_fail++; $display("FAIL to_err got %b want 1", bus_err); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h404 || stall !== 1'b1) begin
      n_fail++; $display("FAIL to_next got req=%b addr=%h stall=%b want 1 404 1", mem_req, mem_addr, stall);
    end
    tick();
    mem_ready = 1'b1;
    sample();
    n_checks++; if (bus_err !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL to_sticky got err=%b stall=%b want 1 0", bus_err, stall);
    end
  endtask

  task automatic test_reset_mid_data();
    tick();
    mem_ready = 1'b1; data_access = 1'b1; data_addr = 32'h5004; data_w = 4'hF; data_out = $urandom;
    tick();
    data_access = 1'b0; mem_ready = 1'b0;
    sample();
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
      n_fail++; $display("FAIL rm_pre got req=%b we=%b want 1 1", mem_req, mem_we);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || stall !== 1'b1 || mwait !== 1'b0) begin
      n_fail++; $display("FAIL rm_async got req=%b we=%b stall=%b mwait=%b want 0 0 1 0", mem_req, mem_we, stall, mwait);
    end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL rm_err got %b want 0", bus_err); end
    @(posedge clock); #1;
    reset = 1'b0; mem_ready = 1'b1; inst_addr = 32'h600;
    sample();
    n_checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin
      n_fail++; $display("FAIL rm_idle got req=%b stall=%b want 0 1", mem_req, stall);
    end
    tick();
    sample();
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h600 || mem_we !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL rm_fetch got req=%b addr=%h we=%b err=%b want 1 600 0 0", mem_req, mem_addr, mem_we, bus_err);
    end
  endtask

  // Reference: the bus serves one transaction at a time; a load/store request is queued
  // behind the current transaction and always beats the next fetch.
  task automatic test_random();
    bit          first, on_data, pend, err, done, to, accept;
    int          waited;
    logic [31:0] l_addr, l_wd, m_inst, m_din, rd;
    logic [3:0]  l_be;
    logic [31:0] e_addr, e_inst, e_din;
    logic [3:0]  e_be;
    bit          e_we, e_stall, e_mwait;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    first = 1; on_data = 0; pend = 0; err = 0; waited = 0;
    l_addr = 0; l_wd = 0; l_be = 0; m_inst = 0; m_din = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      inst_addr   = $urandom;
      mem_ready   = ($urandom_range(0, 9) < 6);
      mem_rdata   = $urandom;
      data_access = ($urandom_range(0, 9) < 2);
      data_addr   = $urandom;
      data_out    = $urandom;
      data_w      = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      sample();
      if (first) begin
        n_checks++; if (mem_req !== 1'b0 || stall !== 1'b1 || mwait !== 1'b0) begin
          n_fail++; $display("FAIL rnd_idle c%0d got req=%b stall=%b mwait=%b", cyc, mem_req, stall, mwait);
        end
        first = 0;
      end else begin
        to     = !mem_ready && (waited + 1 == int'(TO));
        done   = mem_ready || to;
        rd     = mem_ready ? mem_rdata : 32'h0;
        accept = data_access && !pend;
        e_addr = on_data ? (l_addr & ~32'h3) : (inst_addr & ~32'h3);
        e_be   = on_data ? l_be : 4'h0;
        e_we   = on_data && (l_be != 0);
        e_inst = (!on_data && done) ? rd : m_inst;
        e_din  = (on_data && done) ? rd : m_din;
        e_stall = !done || (pend && !(on_data && done));
        e_mwait = accept || (pend && !(on_data && done));
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== e_addr || mem_be !== e_be || mem_we !== e_we) begin
          n_fail++; $display("FAIL rnd_bus c%0d got req=%b addr=%h be=%h we=%b want 1 %h %h %b",
                             cyc, mem_req, mem_addr, mem_be, mem_we, e_addr, e_be, e_we);
        end
        if (on_data && e_we) begin
          n_checks++; if (mem_wdata !== l_wd) begin n_fail++; $display("FAIL rnd_wdata c%0d got %h want %h", cyc, mem_wdata, l_wd); end
        end
        n_checks++; if (inst_in !== e_inst || data_in !== e_din) begin
          n_fail++; $display("FAIL rnd_rdata c%0d got inst=%h din=%h want %h %h", cyc, inst_in, data_in, e_inst, e_din);
        end
        n_checks++; if (stall !== e_stall || mwait !== e_mwait || bus_err !== err) begin
          n_fail++; $display("FAIL rnd_flags c%0d got stall=%b mwait=%b err=%b want %b %b %b",
                             cyc, stall, mwait, bus_err, e_stall, e_mwait, err);
        end
        m_inst = e_inst;
        m_din  = e_din;
        if (done) begin
          waited = 0;
          if (on_data) pend = 0;
          if (to) err = 1;
        end else begin
          waited++;
        end
        if (accept) begin
          pend = 1; l_addr = data_addr; l_wd = data_out; l_be = data_w;
        end
        if (done) on_data = pend;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_fetch();
    test_store_during_fetch();
    test_load();
    test_timeout();
    test_reset_mid_data();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
